alu_exec_unit: RTL and testbench

Parametrised execution stage for the mini-ALU datapath. It sits between the operand-forwarding muxes and the 16-bit/32-bit register files and LED register.
- Accepts one decoded operation per handshake.
- Single-cycle operations return a registered result after 1 cycle.
- MUL/SMUL run on an iterative shift-add multiplier and stall the front end through a ready/valid handshake.
- Generalises the fixed-width combinational ALU to any operand width and adds a multi-cycle multiply.

---
 rtl/alu_exec_pkg.sv | 24 ++
 rtl/seq_multiplier.sv | 85 ++++++++
 rtl/alu_exec_unit.sv | 149 ++++++++++++++
 tb/tb_alu_exec_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg: shared definitions for the mini-ALU execution stage.
//   - 4-bit opcode constants decoded by alu_exec_unit
//   - state encoding of the execution-stage handshake FSM
package alu_exec_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_STO   = 4'd2;
  localparam logic [3:0] OP_BLE   = 4'd3;
  localparam logic [3:0] OP_JMP   = 4'd4;
  localparam logic [3:0] OP_LED   = 4'd5;
  localparam logic [3:0] OP_SUB   = 4'd6;
  localparam logic [3:0] OP_MUL   = 4'd7;
  localparam logic [3:0] OP_SMUL  = 4'd8;
  localparam logic [3:0] OP_ADD32 = 4'd9;
  localparam logic [3:0] OP_SUB32 = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL_RUN = 2'd1,
    ST_DONE    = 2'd2
  } exec_state_t;

endpackage

// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative shift-add multiplier, one multiplier bit per cycle.
// Signed operands are converted to magnitudes up front; the sign is applied
// to the accumulated product on the way out.
// Optional build macro: MUL_EARLY_TERM_EN -- stop iterating once the
// remaining multiplier bits are all zero (result unchanged, latency shorter).
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start         load operands and begin (ignored while busy by the owner)
//   signed_mode   treat a/b as two's complement
//   a, b          multiplicand / multiplier (DATA_W)
//   busy          iteration in progress
//   done          combinational: the current busy cycle is the last iteration
//   product       2*DATA_W result, sign-corrected, stable once busy drops
module seq_multiplier #(
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  signed_mode,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  busy,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  logic [2*DATA_W-1:0] mcand;
  logic [2*DATA_W-1:0] acc;
  logic [DATA_W-1:0]   mplier;
  logic [CNT_W-1:0]    cnt;
  logic                neg;
  logic                lastIter;

  // Magnitude of a possibly-signed operand. The most negative value maps to
  // 2^(DATA_W-1), which still fits in DATA_W unsigned bits.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                  input logic isSigned);
    logic signed [DATA_W-1:0] s;
    s = signed'(v);
    if (isSigned && (s < 0)) return unsigned'(-s);
    return v;
  endfunction

  function automatic logic [2*DATA_W-1:0] applySign(input logic [2*DATA_W-1:0] v,
                                                    input logic isNeg);
    return isNeg ? (~v + (2*DATA_W)'(1)) : v;
  endfunction

`ifdef MUL_EARLY_TERM_EN
  assign lastIter = (cnt == CNT_W'(DATA_W - 1)) || (mplier[DATA_W-1:1] == '0);
`else
  assign lastIter = (cnt == CNT_W'(DATA_W - 1));
`endif

  assign done    = busy && lastIter;
  assign product = applySign(acc, neg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      busy   <= 1'b0;
    end else if (start) begin
      mcand  <= {{DATA_W{1'b0}}, magnitude(a, signed_mode)};
      mplier <= magnitude(b, signed_mode);
      acc    <= '0;
      cnt    <= '0;
      neg    <= signed_mode && (a[DATA_W-1] ^ b[DATA_W-1]);
      busy   <= 1'b1;
    end else if (busy) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (lastIter) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execution stage of the mini-ALU datapath.
// Single-cycle ops register their result on the accept edge; MUL/SMUL hand
// off to seq_multiplier and hold oReady low until the product is delivered.
// Optional build macro: MUL_EARLY_TERM_EN (early multiply termination).
// Ports:
//   Clock, Reset          clock, asynchronous active-low reset
//   iValid / oReady       operation handshake (accept on iValid && oReady)
//   iOperation            opcode (alu_exec_pkg)
//   iSourceData0/1        operands A / B
//   iImmediate            STO value
//   iDestination          destination register or branch target
//   oResultValid          result pulse; qualifies oWriteEnable/oWriteEnableWide
//   oResult               2*DATA_W result, zero-extended for narrow ops
//   oDestination          registered destination / branch target
//   oBranchTaken          branch pulse
//   oLed                  LED register
//   oBusy                 multiplier iterating
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int LED_W  = 8
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                iValid,
  output logic                oReady,
  input  logic [3:0]          iOperation,
  input  logic [DATA_W-1:0]   iSourceData0,
  input  logic [DATA_W-1:0]   iSourceData1,
  input  logic [DATA_W-1:0]   iImmediate,
  input  logic [ADDR_W-1:0]   iDestination,
  output logic                oResultValid,
  output logic [2*DATA_W-1:0] oResult,
  output logic                oWriteEnable,
  output logic                oWriteEnableWide,
  output logic [ADDR_W-1:0]   oDestination,
  output logic                oBranchTaken,
  output logic [LED_W-1:0]    oLed,
  output logic                oBusy
);

  exec_state_t         state;
  logic [ADDR_W-1:0]   mulDest;
  logic                accept;
  logic                mulStart;
  logic                mulDone;
  logic [2*DATA_W-1:0] mulProduct;

  assign accept   = iValid && oReady;
  assign mulStart = accept && (state == ST_IDLE) &&
                    ((iOperation == OP_MUL) || (iOperation == OP_SMUL));

  seq_multiplier #(.DATA_W(DATA_W)) uMul (
    .clk         (Clock),
    .rst_n       (Reset),
    .start       (mulStart),
    .signed_mode (iOperation == OP_SMUL),
    .a           (iSourceData0),
    .b           (iSourceData1),
    .busy        (oBusy),
    .done        (mulDone),
    .product     (mulProduct)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state            <= ST_IDLE;
      oReady           <= 1'b1;
      mulDest          <= '0;
      oResultValid     <= 1'b0;
      oResult          <= '0;
      oWriteEnable     <= 1'b0;
      oWriteEnableWide <= 1'b0;
      oDestination     <= '0;
      oBranchTaken     <= 1'b0;
      oLed             <= '0;
    end else begin
      oResultValid     <= 1'b0;
      oWriteEnable     <= 1'b0;
      oWriteEnableWide <= 1'b0;
      oBranchTaken     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (iOperation)
              OP_ADD, OP_SUB, OP_STO: begin
                if (iOperation == OP_ADD)
                  oResult <= {{DATA_W{1'b0}}, iSourceData1 + iSourceData0};
                else if (iOperation == OP_SUB)
                  oResult <= {{DATA_W{1'b0}}, iSourceData1 - iSourceData0};
                else
                  oResult <= {{DATA_W{1'b0}}, iImmediate};
                oDestination <= iDestination;
                oResultValid <= 1'b1;
                oWriteEnable <= 1'b1;
              end
              OP_ADD32, OP_SUB32: begin
                if (iOperation == OP_ADD32)
                  oResult <= {{DATA_W{1'b0}}, iSourceData1} + {{DATA_W{1'b0}}, iSourceData0};
                else
                  oResult <= {{DATA_W{1'b0}}, iSourceData1} - {{DATA_W{1'b0}}, iSourceData0};
                oDestination     <= iDestination;
                oResultValid     <= 1'b1;
                oWriteEnableWide <= 1'b1;
              end
              OP_BLE: begin
                if (iSourceData1 <= iSourceData0) begin
                  oBranchTaken <= 1'b1;
                  oDestination <= iDestination;
                end
              end
              OP_JMP: begin
                oBranchTaken <= 1'b1;
                oDestination <= iDestination;
              end
              OP_LED: oLed <= iSourceData1[LED_W-1:0];
              OP_MUL, OP_SMUL: begin
                mulDest <= iDestination;
                oReady  <= 1'b0;
                state   <= ST_MUL_RUN;
              end
              default: ;
            endcase
          end
        end
        // multiplier iterating; leave once the final iteration is in flight
        ST_MUL_RUN: begin
          if (mulDone) state <= ST_DONE;
        end
        // product settled and sign-corrected: deliver and reopen the handshake
        ST_DONE: begin
          oResult          <= mulProduct;
          oDestination     <= mulDest;
          oResultValid     <= 1'b1;
          oWriteEnableWide <= 1'b1;
          oReady           <= 1'b1;
          state            <= ST_IDLE;
        end
        default: begin
          oReady <= 1'b1;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;
  import alu_exec_pkg::*;

  logic        Clock;
  logic        Reset;
  logic        iValid;
  logic        oReady;
  logic [3:0]  iOperation;
  logic [15:0] iSourceData0;
  logic [15:0] iSourceData1;
  logic [15:0] iImmediate;
  logic [7:0]  iDestination;
  logic        oResultValid;
  logic [31:0] oResult;
  logic        oWriteEnable;
  logic        oWriteEnableWide;
  logic [7:0]  oDestination;
  logic        oBranchTaken;
  logic [7:0]  oLed;
  logic        oBusy;

  int nChecks = 0;
  int nErrors = 0;

  alu_exec_unit #(.DATA_W(16), .ADDR_W(8), .LED_W(8)) dut (
    .Clock            (Clock),
    .Reset            (Reset),
    .iValid           (iValid),
    .oReady           (oReady),
    .iOperation       (iOperation),
    .iSourceData0     (iSourceData0),
    .iSourceData1     (iSourceData1),
    .iImmediate       (iImmediate),
    .iDestination     (iDestination),
    .oResultValid     (oResultValid),
    .oResult          (oResult),
    .oWriteEnable     (oWriteEnable),
    .oWriteEnableWide (oWriteEnableWide),
    .oDestination     (oDestination),
    .oBranchTaken     (oBranchTaken),
    .oLed             (oLed),
    .oBusy            (oBusy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] imm;
    logic [7:0]  dest;
    logic [31:0] expRes;
    logic        expValid;
    logic        expWe;
    logic        expWeW;
    logic        expBr;
    logic [7:0]  expLed;
  } vec_t;

  vec_t vecs [0:11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int expLatency(input logic [3:0] op, input logic [15:0] b);
`ifdef MUL_EARLY_TERM_EN
    logic [15:0] m;
    int top;
    m = (op == OP_SMUL && b[15]) ? (~b + 16'd1) : b;
    top = -1;
    for (int i = 0; i < 16; i++) if (m[i]) top = i;
    return (top < 0) ? 2 : top + 2;
`else
    return (op == OP_MUL || op == OP_SMUL) ? 17 : 17;
`endif
  endfunction

  task automatic runMul(input string name, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [7:0] dest, input logic [31:0] exp);
    int  expL;
    int  lat;
    bit  seen;
    expL = expLatency(op, b);
    seen = 0;
    lat  = 0;
    @(negedge Clock);
    iValid = 1'b1; iOperation = op; iSourceData0 = a; iSourceData1 = b; iDestination = dest;
    @(posedge Clock); #1;
    check({name, "_ready_low"}, oReady, 0);
    check({name, "_busy"}, oBusy, 1);
    // a different operation offered during the stall must not be taken
    @(negedge Clock);
    iOperation = OP_STO; iImmediate = 16'hDEAD; iDestination = 8'hEE;
    for (int c = 1; c <= 40 && !seen; c++) begin
      if (c > 1) @(posedge Clock);
      else @(posedge Clock);
      #1;
      if (oResultValid) begin
        seen = 1;
        lat  = c;
      end else if (c < expL) begin
        check({name, "_stall_ready"}, oReady, 0);
      end
    end
    @(negedge Clock);
    iValid = 1'b0;
    if (!seen) begin
      check({name, "_timeout"}, 0, 1);
    end else begin
      check({name, "_latency"}, lat, expL);
      check({name, "_result"}, oResult, exp);
      check({name, "_we_wide"}, oWriteEnableWide, 1);
      check({name, "_we_narrow"}, oWriteEnable, 0);
      check({name, "_dest"}, oDestination, dest);
      check({name, "_ready_back"}, oReady, 1);
    end
    @(posedge Clock); #1;
    check({name, "_no_extra_pulse"}, oResultValid, 0);
    check({name, "_idle_busy"}, oBusy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses;
    vecs[0]  = '{OP_ADD,   16'h0003, 16'hFFFF, 16'h0000, 8'h01, 32'h00000002, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{OP_SUB,   16'h0003, 16'h0001, 16'h0000, 8'h02, 32'h0000FFFE, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{OP_STO,   16'h1111, 16'h2222, 16'hBEEF, 8'h03, 32'h0000BEEF, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[3]  = '{OP_ADD32, 16'hFFFF, 16'hFFFF, 16'h0000, 8'h04, 32'h0001FFFE, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[4]  = '{OP_SUB32, 16'h0001, 16'h0000, 16'h0000, 8'h05, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[5]  = '{OP_BLE,   16'h0005, 16'h0005, 16'h0000, 8'h42, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
    vecs[6]  = '{OP_BLE,   16'h0004, 16'h0005, 16'h0000, 8'h43, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[7]  = '{OP_BLE,   16'h0005, 16'h0004, 16'h0000, 8'h44, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
    vecs[8]  = '{OP_JMP,   16'h0000, 16'h0000, 16'h0000, 8'h77, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
    vecs[9]  = '{OP_LED,   16'h0000, 16'h12A5, 16'h0000, 8'h09, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
    vecs[10] = '{OP_NOP,   16'h0001, 16'h0002, 16'h0003, 8'h0A, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
    vecs[11] = '{4'hF,     16'h0001, 16'h0002, 16'h0003, 8'h0B, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};

    Reset = 1'b0; iValid = 1'b0; iOperation = OP_NOP;
    iSourceData0 = '0; iSourceData1 = '0; iImmediate = '0; iDestination = '0;
    repeat (3) @(posedge Clock);
    #1;
    check("reset_ready", oReady, 1);
    check("reset_valid", oResultValid, 0);
    check("reset_result", oResult, 0);
    check("reset_led", oLed, 0);
    check("reset_busy", oBusy, 0);
    @(negedge Clock);
    Reset = 1'b1;

    // back-to-back single-cycle ops
    for (int i = 0; i <= 11; i++) begin
      @(negedge Clock);
      iValid = 1'b1; iOperation = vecs[i].op; iSourceData0 = vecs[i].a;
      iSourceData1 = vecs[i].b; iImmediate = vecs[i].imm; iDestination = vecs[i].dest;
      @(posedge Clock); #1;
      if (vecs[i].op != OP_BLE && vecs[i].op != OP_JMP)
        check($sformatf("vec%0d_valid", i), oResultValid, vecs[i].expValid);
      check($sformatf("vec%0d_we", i), oWriteEnable, vecs[i].expWe);
      check($sformatf("vec%0d_we_wide", i), oWriteEnableWide, vecs[i].expWeW);
      check($sformatf("vec%0d_branch", i), oBranchTaken, vecs[i].expBr);
      check($sformatf("vec%0d_led", i), oLed, vecs[i].expLed);
      check($sformatf("vec%0d_ready", i), oReady, 1);
      if (vecs[i].expValid) begin
        check($sformatf("vec%0d_result", i), oResult, vecs[i].expRes);
        check($sformatf("vec%0d_dest", i), oDestination, vecs[i].dest);
      end
      if (vecs[i].expBr)
        check($sformatf("vec%0d_target", i), oDestination, vecs[i].dest);
    end
    @(negedge Clock);
    iValid = 1'b0;
    @(posedge Clock); #1;
    check("idle_no_pulse", oResultValid, 0);
    check("idle_no_branch", oBranchTaken, 0);

    runMul("mul_ff_101",   OP_MUL,  16'h00FF, 16'h0101, 8'h10, 32'h0000FFFF);
    runMul("smul_min_min", OP_SMUL, 16'h8000, 16'h8000, 8'h11, 32'h40000000);
    runMul("smul_m2_3",    OP_SMUL, 16'hFFFE, 16'h0003, 8'h12, 32'hFFFFFFFA);
    runMul("mul_zero",     OP_MUL,  16'hFFFF, 16'h0000, 8'h13, 32'h00000000);
    runMul("mul_1234_3",   OP_MUL,  16'h1234, 16'h0003, 8'h14, 32'h0000369C);

    // reset during the second MUL_RUN cycle aborts the multiply
    @(negedge Clock);
    iValid = 1'b1; iOperation = OP_MUL; iSourceData0 = 16'h1234; iSourceData1 = 16'h0003;
    iDestination = 8'h20;
    @(posedge Clock);
    @(negedge Clock);
    iValid = 1'b0;
    @(posedge Clock);
    #2;
    Reset = 1'b0;
    #1;
    check("abort_ready", oReady, 1);
    check("abort_busy", oBusy, 0);
    check("abort_valid", oResultValid, 0);
    check("abort_result", oResult, 0);
    check("abort_dest", oDestination, 0);
    check("abort_led", oLed, 0);
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge Clock); #1;
      if (oResultValid) pulses++;
    end
    check("abort_no_pulse", pulses, 0);
    check("abort_ready_after", oReady, 1);

    @(negedge Clock);
    iValid = 1'b1; iOperation = OP_ADD; iSourceData0 = 16'h0003; iSourceData1 = 16'hFFFF;
    iDestination = 8'h30;
    @(posedge Clock); #1;
    check("post_reset_add_valid", oResultValid, 1);
    check("post_reset_add_result", oResult, 32'h00000002);
    check("post_reset_add_dest", oDestination, 8'h30);
    @(negedge Clock);
    iValid = 1'b0;
    @(posedge Clock); #1;
    check("post_reset_add_pulse_end", oResultValid, 0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
